mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 60 ++++++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 72 +++++++
 tb/tb_mem_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and load-type codes for the MEM stage.
// The macros stay available for legacy files that still use the defines header.
`ifndef MEM_STAGE_DEFINES_SVH
`define MEM_STAGE_DEFINES_SVH
`define EX_TO_MEM_WD 80
`define MEM_TO_WB_WD 70
`define StallBus     6
`define Stop         1'b1
`define NoStop       1'b0
`define LB           4'b0001
`define LBU          4'b0010
`define LH           4'b0011
`define LHU          4'b0100
`define LW           4'b1111
`endif

package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_WD = `EX_TO_MEM_WD;
  localparam int unsigned MEM_TO_WB_WD = `MEM_TO_WB_WD;
  localparam int unsigned STALL_BUS_WD = `StallBus;
  localparam int unsigned HILO_WD      = 66;
  localparam int unsigned MEM_TO_ID_WD = 38;

  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;

  localparam logic STOP    = `Stop;
  localparam logic NO_STOP = `NoStop;

  localparam logic [3:0] LD_LB  = `LB;
  localparam logic [3:0] LD_LBU = `LBU;
  localparam logic [3:0] LD_LH  = `LH;
  localparam logic [3:0] LD_LHU = `LHU;
  localparam logic [3:0] LD_LW  = `LW;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [3:0]  ram_read;
  } ex_to_mem_t;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_load(input logic [3:0] code);
    return (code == LD_LB) || (code == LD_LBU) || (code == LD_LH) ||
           (code == LD_LHU) || (code == LD_LW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword of the SRAM word
// and sign- or zero-extends it according to the load-type code.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  code,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // addr[0] is deliberately ignored for halfwords; EX traps misalignment.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    case (code)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      LD_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register with stall/bubble control, load data
// alignment and the WB / ID forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [HILO_WD-1:0]      ex_to_mem1,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [HILO_WD-1:0]      mem_to_wb1,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic [HILO_WD-1:0]      mem_to_id_2
);

  ex_to_mem_t ex_q, ex_d;
  hilo_t      hilo_q, hilo_d;

  logic        stop_exmem;
  logic        stop_memwb;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        use_load;

  assign stop_exmem = (stall[STALL_EXMEM] == STOP);
  assign stop_memwb = (stall[STALL_MEMWB] == STOP);

  // Bubble only when MEM/WB keeps moving; if both stop, hold.
  always_comb begin
    ex_d   = ex_q;
    hilo_d = hilo_q;
    if (stop_exmem && !stop_memwb) begin
      ex_d   = '0;
      hilo_d = '0;
    end else if (!stop_exmem) begin
      ex_d   = ex_to_mem_bus;
      hilo_d = ex_to_mem1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      hilo_q <= '0;
    end else begin
      ex_q   <= ex_d;
      hilo_q <= hilo_d;
    end
  end

  load_align u_load_align (
    .code  (ex_q.ram_read),
    .addr  (ex_q.ex_result[1:0]),
    .rdata (data_sram_rdata),
    .data  (load_data)
  );

  assign use_load = ex_q.sel_rf_res && ex_q.ram_en && is_load(ex_q.ram_read);
  assign rf_wdata = use_load ? load_data : ex_q.ex_result;

  assign mem_to_wb_bus = {ex_q.pc, ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_to_wb1    = hilo_q;
  assign mem_to_id_2   = hilo_q;

  // Byte-write strobes and the other stages' stall bits are not needed here.
  logic unused_bits;
  assign unused_bits = ^{ex_q.ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus stall/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [79:0] ex_to_mem_bus;
  logic [65:0] ex_to_mem1;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] mem_to_wb1;
  logic [37:0] mem_to_id_bus;
  logic [65:0] mem_to_id_2;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_mem1      (ex_to_mem1),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_wb1      (mem_to_wb1),
    .mem_to_id_bus   (mem_to_id_bus),
    .mem_to_id_2     (mem_to_id_2)
  );

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] result;
    logic [31:0] rdata;
    logic        sel;
    logic        en;
    logic        we;
    logic [4:0]  waddr;
    logic [65:0] hilo;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    string       name;
    logic [69:0] wb;
    logic [65:0] hl;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input string n, input logic [3:0] c, input logic [31:0] res,
                              input logic [31:0] rd, input logic s, input logic e,
                              input logic w, input logic [4:0] wa, input logic [65:0] hl,
                              input logic [31:0] exp);
    vec_t v;
    v.name = n; v.code = c; v.result = res; v.rdata = rd; v.sel = s; v.en = e;
    v.we = w; v.waddr = wa; v.hilo = hl; v.exp_wdata = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] pc, input vec_t v, input logic [5:0] st);
    logic [3:0] wen;
    wen = (v.en && !v.we) ? 4'hF : 4'h0;
    ex_to_mem_bus = {pc, v.en, wen, v.sel, v.we, v.waddr, v.result, v.code};
    ex_to_mem1    = v.hilo;
    stall         = st;
  endtask

  task automatic push_vec(input logic [31:0] pc, input vec_t v);
    exp_t e;
    e.name = v.name;
    e.wb   = {pc, v.we, v.waddr, v.exp_wdata};
    e.hl   = v.hilo;
    sb.push_back(e);
  endtask

  task automatic push_zero(input string n);
    exp_t e;
    e.name = n; e.wb = '0; e.hl = '0;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    chk({e.name, " wb_bus"}, mem_to_wb_bus, e.wb);
    chk({e.name, " id_bus"}, {32'd0, mem_to_id_bus}, {32'd0, e.wb[37:0]});
    chk({e.name, " wb1"}, {4'd0, mem_to_wb1}, {4'd0, e.hl});
    chk({e.name, " id_2"}, {4'd0, mem_to_id_2}, {4'd0, e.hl});
  endtask

  // One EX->MEM transfer: drive at negedge, SRAM data after the edge, check at next negedge.
  task automatic step(input logic [31:0] pc, input vec_t v, input logic [5:0] st,
                      input bit exp_zero, input bit use_vec, input vec_t ev, input logic [31:0] epc);
    drive(pc, v, st);
    if (exp_zero) push_zero(v.name);
    else if (use_vec) push_vec(epc, ev);
    @(posedge clk);
    #1 data_sram_rdata = v.rdata;
    @(negedge clk);
    sample();
  endtask

  vec_t a, b;

  initial begin
    rst = 1'b1;
    stall = '0;
    ex_to_mem_bus = '1;
    ex_to_mem1 = '1;
    data_sram_rdata = 32'hFFFF_FFFF;

    vecs.push_back(mk("lb_a3",    LD_LB,   32'h0000_1003, 32'h8011_2233, 1, 1, 1, 5'd2,  {2'b10, 32'h1, 32'h2}, 32'hFFFF_FF80));
    vecs.push_back(mk("lbu_a3",   LD_LBU,  32'h0000_1003, 32'h8011_2233, 1, 1, 1, 5'd3,  {2'b01, 32'h3, 32'h4}, 32'h0000_0080));
    vecs.push_back(mk("lh_a2",    LD_LH,   32'h0000_1002, 32'h8001_7FFF, 1, 1, 1, 5'd4,  {2'b00, 32'h5, 32'h6}, 32'hFFFF_8001));
    vecs.push_back(mk("lhu_a2",   LD_LHU,  32'h0000_1002, 32'h8001_7FFF, 1, 1, 1, 5'd6,  {2'b11, 32'h7, 32'h8}, 32'h0000_8001));
    vecs.push_back(mk("lh_a0",    LD_LH,   32'h0000_1000, 32'h8001_7FFF, 1, 1, 1, 5'd7,  {2'b10, 32'h9, 32'hA}, 32'h0000_7FFF));
    vecs.push_back(mk("alu",      4'b0000, 32'h0000_1234, 32'h5A5A_5A5A, 0, 0, 1, 5'd5,  {2'b11, 32'hAAAA_0000, 32'h0000_5555}, 32'h0000_1234));
    vecs.push_back(mk("lw",       LD_LW,   32'h0000_2000, 32'hDEAD_BEEF, 1, 1, 1, 5'd8,  {2'b01, 32'hB, 32'hC}, 32'hDEAD_BEEF));
    vecs.push_back(mk("lb_a1",    LD_LB,   32'h0000_1001, 32'h8011_2233, 1, 1, 1, 5'd9,  {2'b00, 32'hD, 32'hE}, 32'h0000_0022));
    vecs.push_back(mk("lh_a3",    LD_LH,   32'h0000_1003, 32'h8001_7FFF, 1, 1, 1, 5'd10, {2'b10, 32'hF, 32'h10}, 32'hFFFF_8001));
    vecs.push_back(mk("lbu_a0",   LD_LBU,  32'h0000_1000, 32'h0000_00FF, 1, 1, 1, 5'd11, {2'b01, 32'h11, 32'h12}, 32'h0000_00FF));
    vecs.push_back(mk("lb_a2",    LD_LB,   32'h0000_1002, 32'h00FF_0000, 1, 1, 1, 5'd12, {2'b00, 32'h13, 32'h14}, 32'hFFFF_FFFF));
    vecs.push_back(mk("lhu_a0",   LD_LHU,  32'h0000_1000, 32'h1234_F00D, 1, 1, 1, 5'd13, {2'b11, 32'h15, 32'h16}, 32'h0000_F00D));
    vecs.push_back(mk("store",    4'b0101, 32'h0000_4000, 32'h1111_1111, 0, 1, 0, 5'd0,  {2'b00, 32'h17, 32'h18}, 32'h0000_4000));
    vecs.push_back(mk("sel_noen", LD_LW,   32'h0000_0055, 32'h0000_0099, 1, 0, 1, 5'd14, {2'b10, 32'h19, 32'h1A}, 32'h0000_0055));
    vecs.push_back(mk("st_code",  4'b0111, 32'h0000_0077, 32'h1234_5678, 1, 1, 1, 5'd15, {2'b01, 32'h1B, 32'h1C}, 32'h0000_0077));

    // Reset with garbage on the inputs: everything must read zero.
    @(negedge clk);
    push_zero("reset");
    @(posedge clk);
    @(negedge clk);
    sample();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      pc = 32'hBFC0_0000 + 32'(i * 4);
      step(pc, vecs[i], 6'b000000, 0, 1, vecs[i], pc);
    end

    a = mk("seq_a", 4'b0000, 32'h0000_1234, 32'h0, 0, 0, 1, 5'd5,
           {2'b11, 32'hAAAA_0000, 32'h0000_5555}, 32'h0000_1234);
    b = mk("seq_b", 4'b0000, 32'h0000_BEEF, 32'h0, 0, 0, 1, 5'd9,
           {2'b01, 32'h1357_9BDF, 32'h2468_ACE0}, 32'h0000_BEEF);

    step(32'h0000_0100, a, 6'b000000, 0, 1, a, 32'h0000_0100);
    b.name = "bubble";
    step(32'h0000_0104, b, 6'b001111, 1, 0, a, 32'h0);
    step(32'h0000_0100, a, 6'b000000, 0, 1, a, 32'h0000_0100);
    b.name = "hold";
    step(32'h0000_0104, b, 6'b011111, 0, 1, a, 32'h0000_0100);

    rst = 1'b1;
    b.name = "rst_in_stall";
    step(32'h0000_0104, b, 6'b011111, 1, 0, a, 32'h0);
    rst = 1'b0;
    b.name = "hold_after_rst";
    step(32'h0000_0104, b, 6'b011111, 1, 0, a, 32'h0);
    b.name = "resume";
    step(32'h0000_0104, b, 6'b000000, 0, 1, b, 32'h0000_0104);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard: %0d entries left unchecked, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
